// File: rtl/my_parity_chk_pkg.sv
`default_nettype none
// ============================================================================
// Module   : my_parity_chk_pkg
// Purpose  : Shared definitions for the serial parity checker: FSM state
//            encoding and counter widths.
// Contents : state_e   - IDLE/DATA/PAR/HOLD encoding (2 bits)
//            ERRCNT_W  - width of the saturating error counter
//            CNT_W     - width of the data-bit counter (FRAME_LEN <= 15)
// Revision : 1.0 - initial release
// ============================================================================
package my_parity_chk_pkg;

  localparam int ERRCNT_W = 8;
  localparam int CNT_W    = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_PAR  = 2'd2,
    S_HOLD = 2'd3
  } state_e;

endpackage : my_parity_chk_pkg
`default_nettype wire

// File: rtl/my_xor2.sv
`default_nettype none
// ============================================================================
// Module   : my_xor2
// Purpose  : Two-input XOR gate from the basic-gates set.
// Ports    : a_i, b_i - operands
//            y_o      - a_i ^ b_i
// Revision : 1.0 - initial release
// ============================================================================
module my_xor2 (
  input  logic a_i,
  input  logic b_i,
  output logic y_o
);

  assign y_o = a_i ^ b_i;

endmodule : my_xor2
`default_nettype wire

// File: rtl/my_parity_chk.sv
`default_nettype none
// ============================================================================
// Module   : my_parity_chk
// Purpose  : Serial parity checker. Accepts FRAME_LEN data bits followed by
//            one parity bit, reassembles the data word (first bit at bit 0)
//            and presents pass/fail under a valid/ready handshake.
// Ports    : clk, rst_n          - clock, asynchronous active-low reset
//            start, parity_odd   - frame start (IDLE only), parity mode
//            bit_in, bit_valid   - serial input stream
//            bit_ready           - high in DATA and PAR
//            res_valid/res_ready - result handshake
//            err, data_out       - result (stable while res_valid)
//            err_cnt             - saturating error count
// Macro    : MY_PARITY_ERRCNT_EN - enables err_cnt; otherwise it is tied 0
// Revision : 1.0 - initial release
// ============================================================================
module my_parity_chk
  import my_parity_chk_pkg::*;
#(
  parameter int FRAME_LEN = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 parity_odd,
  input  logic                 bit_in,
  input  logic                 bit_valid,
  output logic                 bit_ready,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic                 err,
  output logic [FRAME_LEN-1:0] data_out,
  output logic [ERRCNT_W-1:0]  err_cnt
);

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(FRAME_LEN - 1);

  state_e               state_q, state_d;
  logic                 acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [FRAME_LEN-1:0] sr_q, sr_d;
  logic                 odd_q, odd_d;
  logic                 err_q, err_d;
  logic [FRAME_LEN-1:0] data_q, data_d;

  logic                 w_accept;
  logic                 w_acc_x;
  logic [FRAME_LEN-1:0] w_sr_shift;

  // Outputs are pure decodes of the registered state.
  assign bit_ready = (state_q == S_DATA) || (state_q == S_PAR);
  assign res_valid = (state_q == S_HOLD);
  assign w_accept  = bit_valid & bit_ready;
  assign err       = err_q;
  assign data_out  = data_q;

  // Running parity; in PAR the same gate output gives acc ^ parity_bit.
  my_xor2 u_acc_xor (
    .a_i (acc_q),
    .b_i (bit_in),
    .y_o (w_acc_x)
  );

  // Shift right so the first bit received ends up in bit 0.
  if (FRAME_LEN == 1) begin : g_sr_single
    assign w_sr_shift = bit_in;
  end else begin : g_sr_multi
    assign w_sr_shift = {bit_in, sr_q[FRAME_LEN-1:1]};
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    odd_d   = odd_q;
    err_d   = err_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_DATA;
          acc_d   = 1'b0;
          cnt_d   = '0;
          odd_d   = parity_odd;
        end
      end
      S_DATA: begin
        if (w_accept) begin
          acc_d = w_acc_x;
          sr_d  = w_sr_shift;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == C_LAST) begin
            state_d = S_PAR;
          end
        end
      end
      S_PAR: begin
        if (w_accept) begin
          // Odd mode expects total parity 1, so fold the mode bit in.
          err_d   = w_acc_x ^ odd_q;
          data_d  = sr_q;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (res_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= 1'b0;
      cnt_q   <= '0;
      sr_q    <= '0;
      odd_q   <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      odd_q   <= odd_d;
      err_q   <= err_d;
      data_q  <= data_d;
    end
  end

`ifdef MY_PARITY_ERRCNT_EN
  logic [ERRCNT_W-1:0] errcnt_q, errcnt_d;

  always_comb begin
    errcnt_d = errcnt_q;
    if (res_valid && res_ready && err_q && (errcnt_q != '1)) begin
      errcnt_d = errcnt_q + ERRCNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      errcnt_q <= '0;
    end else begin
      errcnt_q <= errcnt_d;
    end
  end

  assign err_cnt = errcnt_q;
`else
  assign err_cnt = '0;
`endif

endmodule : my_parity_chk
`default_nettype wire

// File: tb/tb_my_parity_chk.sv
`default_nettype none
// ============================================================================
// Module   : tb_my_parity_chk
// Purpose  : Self-checking bench for my_parity_chk. Frames are modelled as a
//            data word plus parity bit; expected err comes from the XOR
//            reduction of the word, expected err_cnt from a counted total.
// Macro    : MY_PARITY_ERRCNT_EN - selects the expected err_cnt behaviour
// Revision : 1.0 - initial release
// ============================================================================
module tb_my_parity_chk;

  localparam int FL = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          parity_odd;
  logic          bit_in;
  logic          bit_valid;
  logic          bit_ready;
  logic          res_valid;
  logic          res_ready;
  logic          err;
  logic [FL-1:0] data_out;
  logic [7:0]    err_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_errs = 0;

  my_parity_chk #(.FRAME_LEN(FL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .parity_odd (parity_odd),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .bit_ready  (bit_ready),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .err        (err),
    .data_out   (data_out),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [7:0] exp_cnt_out();
`ifdef MY_PARITY_ERRCNT_EN
    return (exp_errs > 255) ? 8'd255 : 8'(exp_errs);
`else
    return 8'd0;
`endif
  endfunction

  // Present one bit after 'gap' idle cycles; called and returns at a negedge.
  task automatic drive_bit(input logic b, input int gap);
    repeat (gap) begin
      bit_valid = 1'b0;
      bit_in    = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    bit_valid = 1'b1;
    bit_in    = b;
    n_checks++;
    if ({bit_ready, res_valid} !== 2'b10)
      $display("FAIL accept_ready: got ready=%b valid=%b want ready=1 valid=0",
               bit_ready, res_valid);
    else n_pass++;
    @(negedge clk);
    bit_valid = 1'b0;
  endtask

  // One full frame from IDLE through handshake; entered at a negedge in IDLE.
  task automatic run_frame(input logic [FL-1:0] data, input logic pbit,
                           input logic odd, input int gmin, input int gmax,
                           input int hold, input logic start_in_hs,
                           input string tag);
    logic exp_err;
    exp_err = (^data) ^ pbit ^ odd;
    start      = 1'b1;
    parity_odd = odd;
    // A bit offered alongside start must be dropped.
    bit_valid  = 1'($urandom_range(0, 1));
    bit_in     = 1'($urandom_range(0, 1));
    n_checks++;
    if ({bit_ready, res_valid} !== 2'b00)
      $display("FAIL %s_idle: got ready=%b valid=%b want 0 0", tag, bit_ready, res_valid);
    else n_pass++;
    @(negedge clk);
    start      = 1'b0;
    parity_odd = ~odd;  // mode must have been latched on the start edge
    for (int i = 0; i < FL; i++)
      drive_bit(data[i], $urandom_range(gmin, gmax));
    drive_bit(pbit, $urandom_range(gmin, gmax));
    res_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      n_checks++;
      if ({res_valid, bit_ready, err, data_out} !== {1'b1, 1'b0, exp_err, data})
        $display("FAIL %s_hold%0d: got v=%b r=%b err=%b data=%h want v=1 r=0 err=%b data=%h",
                 tag, h, res_valid, bit_ready, err, data_out, exp_err, data);
      else n_pass++;
      start     = 1'($urandom_range(0, 1));
      bit_valid = 1'($urandom_range(0, 1));
      bit_in    = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    n_checks++;
    if ({res_valid, bit_ready, err, data_out} !== {1'b1, 1'b0, exp_err, data})
      $display("FAIL %s_result: got v=%b r=%b err=%b data=%h want v=1 r=0 err=%b data=%h",
               tag, res_valid, bit_ready, err, data_out, exp_err, data);
    else n_pass++;
    res_ready = 1'b1;
    start     = start_in_hs;
    bit_valid = 1'b0;
    @(negedge clk);
    res_ready = 1'b0;
    start     = 1'b0;
    if (exp_err) exp_errs++;
    n_checks++;
    if ({res_valid, bit_ready, err_cnt} !== {1'b0, 1'b0, exp_cnt_out()})
      $display("FAIL %s_handshake: got v=%b r=%b cnt=%0d want v=0 r=0 cnt=%0d",
               tag, res_valid, bit_ready, err_cnt, exp_cnt_out());
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bit_ready, res_valid, err, data_out, err_cnt} !== '0)
      $display("FAIL reset_values: got r=%b v=%b err=%b data=%h cnt=%0d want all 0",
               bit_ready, res_valid, err, data_out, err_cnt);
    else n_pass++;
    rst_n    = 1'b1;
    exp_errs = 0;
    for (int i = 0; i < 4; i++) begin
      bit_valid = 1'b1;
      bit_in    = 1'($urandom_range(0, 1));
      @(negedge clk);
      n_checks++;
      if ({bit_ready, res_valid} !== 2'b00)
        $display("FAIL reset_idle%0d: got r=%b v=%b want 0 0", i, bit_ready, res_valid);
      else n_pass++;
    end
    bit_valid = 1'b0;
  endtask

  task automatic test_even_pass();
    run_frame(8'hB2, 1'b0, 1'b0, 0, 0, 0, 1'b0, "even_pass");
  endtask

  task automatic test_even_fail();
    run_frame(8'hB2, 1'b1, 1'b0, 0, 0, 0, 1'b0, "even_fail");
  endtask

  task automatic test_odd_gaps();
    run_frame(8'h01, 1'b0, 1'b1, 2, 2, 0, 1'b0, "odd_gaps");
  endtask

  task automatic test_backpressure();
    run_frame(8'h5C, 1'b1, 1'b1, 0, 1, 5, 1'b1, "backpressure");
    // start during the handshake cycle must not have launched a frame
    @(negedge clk);
    n_checks++;
    if ({bit_ready, res_valid} !== 2'b00)
      $display("FAIL bp_start_ignored: got r=%b v=%b want 0 0", bit_ready, res_valid);
    else n_pass++;
  endtask

  task automatic test_reset_midframe();
    start      = 1'b1;
    parity_odd = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) drive_bit(1'b1, 0);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bit_ready, res_valid, err, data_out, err_cnt} !== '0)
      $display("FAIL midreset_async: got r=%b v=%b err=%b data=%h cnt=%0d want all 0",
               bit_ready, res_valid, err, data_out, err_cnt);
    else n_pass++;
    exp_errs = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      bit_valid = 1'b1;
      bit_in    = 1'b1;
      @(negedge clk);
    end
    bit_valid = 1'b0;
    n_checks++;
    if ({bit_ready, res_valid} !== 2'b00)
      $display("FAIL midreset_no_result: got r=%b v=%b want 0 0", bit_ready, res_valid);
    else n_pass++;
    run_frame(8'h3A, 1'b1, 1'b0, 0, 1, 1, 1'b0, "after_reset");
  endtask

  task automatic test_back_to_back();
    run_frame(8'hFF, 1'b1, 1'b0, 0, 0, 0, 1'b0, "b2b_a");
    run_frame(8'h00, 1'b0, 1'b1, 0, 0, 0, 1'b0, "b2b_b");
    run_frame(8'h80, 1'b0, 1'b1, 0, 0, 0, 1'b0, "b2b_c");
  endtask

  task automatic test_random();
    for (int f = 0; f < 24; f++) begin
      run_frame(8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                0, 3, $urandom_range(0, 3), 1'($urandom_range(0, 1)), "rand");
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    parity_odd = 1'b0;
    bit_in     = 1'b0;
    bit_valid  = 1'b0;
    res_ready  = 1'b0;
    @(negedge clk);
    test_reset();
    test_even_pass();
    test_even_fail();
    test_odd_gaps();
    test_backpressure();
    test_reset_midframe();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_my_parity_chk
`default_nettype wire
